cs_packer: RTL and testbench
============================

CS_PACKER -- requirements
Module: cs_packer

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the control-vector width (analog state count); legal range 3..8.
REQ-002 The block SHALL have parameter SLOTS, default 7, meaning control vectors per packed word pair.
REQ-003 The block SHALL have parameter RS2_SLOTS, default 4, meaning vectors placed in rs2; RS1_SLOTS = SLOTS-RS2_SLOTS; both RS2_SLOTS*N and RS1_SLOTS*N SHALL be <= 32 (elaboration error otherwise).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port s_valid, input, 1 bit: a new control vector is present this cycle (no backpressure to the modulator).
REQ-007 The block SHALL have port s_data, input, N bits: the control vector.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous discard of the partial group and the held word.
REQ-009 The block SHALL have port w_valid, output, 1 bit: a packed word pair is held.
REQ-010 The block SHALL have port w_ready, input, 1 bit: the consumer (CPU issuing the S-shift/calculate instruction) takes the word this cycle.
REQ-011 The block SHALL have port w_rs1, output, 32 bits: the older vectors, sent as the rs1 operand.
REQ-012 The block SHALL have port w_rs2, output, 32 bits: the newer vectors, sent as the rs2 operand.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag, a completed group was dropped.
REQ-014 The block SHALL have port drop_cnt, output, 16 bits: saturating count of dropped groups.

Function
REQ-015 An assembly counter cnt (0..SLOTS-1) SHALL advance on every accepted sample; vector accepted with cnt=j is sample j of the group (0 = oldest).
REQ-016 Sample j < RS1_SLOTS SHALL be placed in w_rs1[(j+1)*N-1 : j*N]; sample j >= RS1_SLOTS SHALL be placed in w_rs2[(j-RS1_SLOTS+1)*N-1 : (j-RS1_SLOTS)*N]; all unused upper bits SHALL be 0.
REQ-017 On acceptance with cnt=SLOTS-1, cnt SHALL wrap to 0 and the group SHALL complete in that same edge.
REQ-018 The output holder SHALL be a two-state FSM, EMPTY (w_valid=0) and FULL (w_valid=1).
REQ-019 Completion in EMPTY: the holder SHALL load the group and enter FULL; w_valid SHALL assert the cycle after the last sample edge (latency 1).
REQ-020 w_valid=1 and w_ready=1 SHALL be a transfer; with no completion the same edge, FULL SHALL return to EMPTY.
REQ-021 Transfer and completion on the same edge: the holder SHALL load the new group and stay FULL; no drop.
REQ-022 Completion in FULL without transfer: the new group SHALL be discarded, the held word SHALL be unchanged, overflow SHALL set, and drop_cnt SHALL increment, saturating at 0xFFFF.
REQ-023 w_rs1/w_rs2 SHALL be stable while w_valid=1 and w_ready=0; w_ready while EMPTY SHALL have no effect.
REQ-024 clr=1 SHALL set cnt=0, clear the assembly register, and force EMPTY; a same-cycle s_valid sample SHALL be ignored; overflow and drop_cnt SHALL be unchanged.
REQ-025 Gaps in s_valid SHALL not affect packing; cnt SHALL hold while s_valid=0.

Reset
REQ-026 When resetn=0 at a clock edge: cnt=0, assembly register=0, FSM=EMPTY, w_valid=0, w_rs1=0, w_rs2=0, overflow=0, drop_cnt=0; reset SHALL dominate clr and s_valid.
REQ-027 Reset mid-group SHALL discard the partial group; the first sample after release SHALL be sample 0.

Verification
REQ-028 Defaults, w_ready=1, s_data=0x01..0x07 on consecutive cycles -> w_valid=1 one cycle later with w_rs1=0x00030201 and w_rs2=0x07060504, a single-cycle pulse.
REQ-029 w_ready=0, feed 14 samples 0x01..0x0E -> w_rs1=0x00030201 held; overflow=1, drop_cnt=1; then w_ready=1 for one cycle -> w_valid=0.
REQ-030 Holder FULL, w_ready=1 on the same edge as the 7th sample of the next group (0x11..0x17) -> w_valid stays 1, w_rs2=0x17161514, drop_cnt=0.
REQ-031 resetn=0 after 3 samples, release, feed 0xA0..0xA6 -> w_rs1=0x00A2A1A0 and w_rs2=0xA6A5A4A3.
REQ-032 N=3, SLOTS=20, RS2_SLOTS=10, all samples 3'b101 -> w_rs1=w_rs2=0x2DB6DB6D (bits 31:30 = 0).
REQ-033 clr asserted with s_valid on sample 4 -> no word produced until 7 further samples; overflow unchanged.

Source files
------------

// File: rtl/cs_packer.sv
// Packs SLOTS consecutive N-bit control vectors into an rs1/rs2 word pair and
// holds it in a one-deep output register; groups completed while full are dropped.
module cs_packer #(
  parameter int unsigned N         = 8,
  parameter int unsigned SLOTS     = 7,
  parameter int unsigned RS2_SLOTS = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         s_valid,
  input  logic [N-1:0] s_data,
  input  logic         clr,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_rs1,
  output logic [31:0]  w_rs2,
  output logic         overflow,
  output logic [15:0]  drop_cnt
);

  localparam int unsigned RS1_SLOTS = SLOTS - RS2_SLOTS;
  localparam int unsigned CntW      = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(SLOTS - 1);

  generate
    if (RS2_SLOTS > SLOTS || RS2_SLOTS * N > 32 || (SLOTS - RS2_SLOTS) * N > 32 ||
        N < 3 || N > 8) begin : g_bad_cfg
      $error("cs_packer: illegal N/SLOTS/RS2_SLOTS combination");
    end
  endgenerate

  typedef enum logic {StEmpty, StFull} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [SLOTS-1:0][N-1:0]   asm_q, asm_d;
  logic [31:0]               rs1_q, rs1_d, rs2_q, rs2_d;
  logic                      ovf_q, ovf_d;
  logic [15:0]               drop_q, drop_d;

  logic [SLOTS-1:0][N-1:0]   grp;
  logic [31:0]               pack1, pack2;
  logic                      accept, complete, xfer;

  // Group as it looks after this edge's sample is written, so completion can
  // load the holder in the same edge as the last sample.
  always_comb begin
    grp = asm_q;
    if (s_valid) grp[cnt_q] = s_data;
    pack1 = '0;
    pack2 = '0;
    for (int j = 0; j < int'(RS1_SLOTS); j++) pack1[j*N +: N] = grp[j];
    for (int k = 0; k < int'(RS2_SLOTS); k++) pack2[k*N +: N] = grp[RS1_SLOTS + k];
  end

  assign accept   = s_valid && !clr;
  assign complete = accept && (cnt_q == LastCnt);
  assign xfer     = (state_q == StFull) && w_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (clr) begin
      cnt_d   = '0;
      asm_d   = '0;
      state_d = StEmpty;
    end else begin
      if (accept) begin
        asm_d = grp;
        cnt_d = complete ? '0 : cnt_q + CntW'(1);
      end
      unique case (state_q)
        StEmpty: begin
          if (complete) begin
            rs1_d   = pack1;
            rs2_d   = pack2;
            state_d = StFull;
          end
        end
        StFull: begin
          if (complete && xfer) begin
            rs1_d = pack1;
            rs2_d = pack2;
          end else if (complete) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          end else if (xfer) begin
            state_d = StEmpty;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StEmpty;
      cnt_q   <= '0;
      asm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign w_valid  = (state_q == StFull);
  assign w_rs1    = rs1_q;
  assign w_rs2    = rs2_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_cs_packer.sv
// Self-checking bench for cs_packer: constant vector table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_cs_packer;

  logic        clk = 1'b0;
  logic        resetn, s_valid, clr, w_ready;
  logic [7:0]  s_data;
  logic        w_valid, overflow;
  logic [31:0] w_rs1, w_rs2;
  logic [15:0] drop_cnt;

  logic        b_resetn = 1'b0, b_valid = 1'b0;
  logic [2:0]  b_data = 3'b000;
  logic        b_w_valid, b_overflow;
  logic [31:0] b_rs1, b_rs2;
  logic [15:0] b_drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cs_packer dut (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_data(s_data), .clr(clr),
    .w_valid(w_valid), .w_ready(w_ready), .w_rs1(w_rs1), .w_rs2(w_rs2),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  cs_packer #(.N(3), .SLOTS(20), .RS2_SLOTS(10)) dut_b (
    .clk(clk), .resetn(b_resetn), .s_valid(b_valid), .s_data(b_data), .clr(1'b0),
    .w_valid(b_w_valid), .w_ready(1'b0), .w_rs1(b_rs1), .w_rs2(b_rs2),
    .overflow(b_overflow), .drop_cnt(b_drop)
  );

  // Reference model: pending samples in a queue, holder as a flag plus word pair.
  bit [7:0]  mq[$];
  bit        m_full;
  bit [31:0] m_rs1, m_rs2;
  bit        m_ovf;
  int        m_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit rstn, input bit sv, input bit [7:0] d,
                              input bit c, input bit rdy);
    bit xfer, done;
    bit [31:0] n1, n2;
    if (!rstn) begin
      mq.delete(); m_full = 0; m_rs1 = 0; m_rs2 = 0; m_ovf = 0; m_drop = 0;
    end else if (c) begin
      mq.delete(); m_full = 0;
    end else begin
      xfer = m_full && rdy;
      done = 0;
      n1 = 0; n2 = 0;
      if (sv) begin
        mq.push_back(d);
        if (mq.size() == 7) begin
          done = 1;
          for (int j = 0; j < 3; j++) n1 += 32'(mq[j]) << (8 * j);
          for (int j = 3; j < 7; j++) n2 += 32'(mq[j]) << (8 * (j - 3));
          mq.delete();
        end
      end
      if (done) begin
        if (!m_full || xfer) begin
          m_full = 1; m_rs1 = n1; m_rs2 = n2;
        end else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end else if (xfer) begin
        m_full = 0;
      end
    end
  endtask

  task automatic model_check();
    check("model_w_valid", 32'(w_valid), 32'(m_full));
    if (m_full) begin
      check("model_w_rs1", w_rs1, m_rs1);
      check("model_w_rs2", w_rs2, m_rs2);
    end
    check("model_overflow", 32'(overflow), 32'(m_ovf));
    check("model_drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic step(input bit rstn, input bit sv, input bit [7:0] d,
                      input bit c, input bit rdy);
    resetn = rstn; s_valid = sv; s_data = d; clr = c; w_ready = rdy;
    @(posedge clk);
    model_update(rstn, sv, d, c, rdy);
    #1;
    model_check();
  endtask

  typedef struct {
    bit        sv;
    bit [7:0]  d;
    bit        rdy;
    bit        ev;
    bit [31:0] e1;
    bit [31:0] e2;
  } vec_t;

  vec_t tbl[8];

  initial begin
    for (int i = 0; i < 7; i++)
      tbl[i] = '{sv: 1, d: 8'(i + 1), rdy: 1, ev: (i == 6), e1: 32'h0003_0201,
                 e2: 32'h0706_0504};
    tbl[7] = '{sv: 0, d: 8'h00, rdy: 1, ev: 0, e1: 32'h0003_0201, e2: 32'h0706_0504};

    // Reset state, reset dominating clr and s_valid
    step(0, 1, 8'hFF, 1, 1);
    check("reset_w_valid", 32'(w_valid), 0);
    check("reset_w_rs1", w_rs1, 0);
    check("reset_w_rs2", w_rs2, 0);
    check("reset_overflow", 32'(overflow), 0);
    check("reset_drop_cnt", 32'(drop_cnt), 0);

    // Seven samples, single-cycle w_valid pulse
    for (int i = 0; i < 8; i++) begin
      step(1, tbl[i].sv, tbl[i].d, 0, tbl[i].rdy);
      check($sformatf("tbl%0d_w_valid", i), 32'(w_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_w_rs1", i), w_rs1, tbl[i].e1);
        check($sformatf("tbl%0d_w_rs2", i), w_rs2, tbl[i].e2);
      end
    end

    // Overflow: 14 samples with the consumer stalled
    step(0, 0, 0, 0, 0);
    for (int i = 1; i <= 14; i++) step(1, 1, 8'(i), 0, 0);
    check("ovf_w_valid", 32'(w_valid), 1);
    check("ovf_w_rs1_held", w_rs1, 32'h0003_0201);
    check("ovf_w_rs2_held", w_rs2, 32'h0706_0504);
    check("ovf_overflow", 32'(overflow), 1);
    check("ovf_drop_cnt", 32'(drop_cnt), 1);
    step(1, 0, 0, 0, 1);
    check("ovf_drain_w_valid", 32'(w_valid), 0);

    // clr with s_valid on sample 4; overflow/drop_cnt survive clr
    for (int i = 0; i < 3; i++) step(1, 1, 8'h30 + 8'(i), 0, 1);
    step(1, 1, 8'h33, 1, 1);
    check("clr_overflow", 32'(overflow), 1);
    check("clr_drop_cnt", 32'(drop_cnt), 1);
    for (int i = 0; i < 6; i++) step(1, 1, 8'h40 + 8'(i), 0, 0);
    check("clr_no_word_yet", 32'(w_valid), 0);
    step(1, 1, 8'h46, 0, 0);
    check("clr_word_after_7", 32'(w_valid), 1);
    check("clr_w_rs1", w_rs1, 32'h0042_4140);

    // Transfer and completion on the same edge
    step(0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) step(1, 1, 8'(i), 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 8'h11 + 8'(i), 0, 0);
    step(1, 1, 8'h17, 0, 1);
    check("same_edge_w_valid", 32'(w_valid), 1);
    check("same_edge_w_rs1", w_rs1, 32'h0013_1211);
    check("same_edge_w_rs2", w_rs2, 32'h1716_1514);
    check("same_edge_drop_cnt", 32'(drop_cnt), 0);

    // Reset mid-group discards the partial group
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 8'h55, 0, 0);
    step(0, 1, 8'h66, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 8'hA0 + 8'(i), 0, 0);
    check("rst_mid_w_rs1", w_rs1, 32'h00A2_A1A0);
    check("rst_mid_w_rs2", w_rs2, 32'hA6A5_A4A3);

    // Randomized traffic against the model
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7), 8'($urandom()),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0));
    end

    // N=3, SLOTS=20, RS2_SLOTS=10 instance
    b_resetn = 1'b0;
    @(posedge clk); #1;
    b_resetn = 1'b1; b_valid = 1'b1; b_data = 3'b101;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
    end
    check("n3_before_last_w_valid", 32'(b_w_valid), 0);
    @(posedge clk); #1;
    b_valid = 1'b0;
    check("n3_w_valid", 32'(b_w_valid), 1);
    check("n3_w_rs1", b_rs1, 32'h2DB6_DB6D);
    check("n3_w_rs2", b_rs2, 32'h2DB6_DB6D);
    check("n3_drop_cnt", 32'(b_drop), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
